// File: rtl/params_pkg.sv
// Shared core parameters and the writeback source encoding used by the
// register-file write-port arbiter.
package params_pkg;

    localparam int unsigned REGISTER_WIDTH  = 5;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned WB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_MEM,
        WB_MUL,
        WB_ALU
    } wb_src_t;

endpackage

// File: rtl/wb_wait_counter.sv
// Saturating count of consecutive denied request cycles; sat flags that the
// requester has waited LIMIT cycles and is due for promotion.
module wb_wait_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [7:0] count;

    // Clear dominates increment so a flush or grant always restarts the wait.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 8'd1;
        end
    end

    assign sat = (count == 8'(LIMIT));

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: MEM > MUL > ALU with combinational grants
// and a one-cycle write stage. Define WB_ARB_STARVE_GUARD_EN for ALU promotion.
module wb_arbiter
    import params_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int unsigned STARVE_LIMIT   = params_pkg::WB_STARVE_LIMIT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      mem_req_i,
    input  logic                      mul_req_i,
    input  logic                      alu_req_i,
    input  logic [REGISTER_WIDTH-1:0] mem_reg_i,
    input  logic [REGISTER_WIDTH-1:0] mul_reg_i,
    input  logic [REGISTER_WIDTH-1:0] alu_reg_i,
    input  logic [DATA_WIDTH-1:0]     mem_data_i,
    input  logic [DATA_WIDTH-1:0]     mul_data_i,
    input  logic [DATA_WIDTH-1:0]     alu_data_i,
    output logic                      mem_grant_o,
    output logic                      mul_grant_o,
    output logic                      alu_grant_o,
    output logic                      rf_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] rf_wr_reg_o,
    output logic [DATA_WIDTH-1:0]     rf_wr_data_o,
    output wb_src_t                   rf_wr_src_o
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("wb_arbiter: STARVE_LIMIT must be in 1..255");
    end

    logic                      alu_promote;
    wb_src_t                   win_src;
    logic [REGISTER_WIDTH-1:0] win_reg;
    logic [DATA_WIDTH-1:0]     win_data;

`ifdef WB_ARB_STARVE_GUARD_EN
    logic alu_sat;
    logic mul_sat;

    wb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_alu_wait (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (alu_req_i & ~alu_grant_o),
        .clr   (flush_i | ~alu_req_i | alu_grant_o),
        .sat   (alu_sat)
    );

    wb_wait_counter #(.LIMIT(STARVE_LIMIT)) u_mul_wait (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (mul_req_i & ~mul_grant_o),
        .clr   (flush_i | ~mul_req_i | mul_grant_o),
        .sat   (mul_sat)
    );

    // When both have saturated MUL keeps its default precedence.
    assign alu_promote = alu_sat & ~mul_sat;
`else
    assign alu_promote = 1'b0;
`endif

    // Grants read zero during reset so nothing leaks out before release.
    always_comb begin
        mem_grant_o = 1'b0;
        mul_grant_o = 1'b0;
        alu_grant_o = 1'b0;
        win_src     = WB_NONE;
        win_reg     = mem_reg_i;
        win_data    = mem_data_i;
        if (!rst_i && !flush_i) begin
            if (mem_req_i) begin
                mem_grant_o = 1'b1;
                win_src     = WB_MEM;
            end else if (alu_req_i && (!mul_req_i || alu_promote)) begin
                alu_grant_o = 1'b1;
                win_src     = WB_ALU;
                win_reg     = alu_reg_i;
                win_data    = alu_data_i;
            end else if (mul_req_i) begin
                mul_grant_o = 1'b1;
                win_src     = WB_MUL;
                win_reg     = mul_reg_i;
                win_data    = mul_data_i;
            end
        end
    end

    // x0 writes are retired through the port but never enable the write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rf_wr_en_o   <= 1'b0;
            rf_wr_reg_o  <= '0;
            rf_wr_data_o <= '0;
            rf_wr_src_o  <= WB_NONE;
        end else if (win_src != WB_NONE) begin
            rf_wr_en_o   <= (win_reg != '0);
            rf_wr_reg_o  <= win_reg;
            rf_wr_data_o <= win_data;
            rf_wr_src_o  <= win_src;
        end else begin
            rf_wr_en_o   <= 1'b0;
            rf_wr_src_o  <= WB_NONE;
        end
    end

endmodule
